// File: rtl/active_min_max_scanner.sv
// rtl/active_min_max_scanner.sv - sequential signed min/max scanner over masked candidates
//
// Snapshots a packed vector of signed numbers plus an activation mask on
// start, then visits one element per clock in ascending index order. It keeps
// the minimum (mode=0) or the maximum (mode=1) of the active elements.
// Optional feature macro: ACTIVE_MIN_MAX_INDEX_EN adds winner-index tracking
// and the result_index port.
//
// Ports:
//   clk               rising-edge clock
//   rst_n             asynchronous active-low reset
//   numbers           packed candidates, element i at [i*NUMBER_SIZE +: NUMBER_SIZE]
//   activations       bit i set = element i participates
//   mode              0 = minimum, 1 = maximum
//   start             scan request, only honoured in IDLE
//   busy              high while scanning or finishing
//   done              one-cycle pulse, results valid from this cycle
//   result            extreme value of the active elements (0 if none active)
//   result_activation high if at least one element was active
//   result_index      winner position (ACTIVE_MIN_MAX_INDEX_EN only)

module active_min_max_scanner #(
   parameter int NUMBER_SIZE       = 4,
   parameter int NUMBER_OF_NUMBERS = 8,
   localparam int IW = ($clog2(NUMBER_OF_NUMBERS) < 1) ? 1 : $clog2(NUMBER_OF_NUMBERS)
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic [NUMBER_SIZE*NUMBER_OF_NUMBERS-1:0] numbers,
   input  logic [NUMBER_OF_NUMBERS-1:0]             activations,
   input  logic                                     mode,
   input  logic                                     start,
   output logic                                     busy,
   output logic                                     done,
   output logic [NUMBER_SIZE-1:0]                   result,
   output logic                                     result_activation
`ifdef ACTIVE_MIN_MAX_INDEX_EN
   ,
   output logic [IW-1:0]                            result_index
`endif
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [IW-1:0] LAST_IDX = IW'(NUMBER_OF_NUMBERS - 1);

   state_t                                   state_q, state_d;
   logic [NUMBER_SIZE*NUMBER_OF_NUMBERS-1:0] nums_q, nums_d;
   logic [NUMBER_OF_NUMBERS-1:0]             act_q, act_d;
   logic                                     mode_q, mode_d;
   logic [IW-1:0]                            cnt_q, cnt_d;
   logic signed [NUMBER_SIZE-1:0]            acc_q, acc_d;
   logic                                     acc_valid_q, acc_valid_d;
   logic [NUMBER_SIZE-1:0]                   result_q, result_d;
   logic                                     result_act_q, result_act_d;
   logic                                     done_q, done_d;
`ifdef ACTIVE_MIN_MAX_INDEX_EN
   logic [IW-1:0]                            acc_idx_q, acc_idx_d;
   logic [IW-1:0]                            result_idx_q, result_idx_d;
`endif

   logic signed [NUMBER_SIZE-1:0]            cur_elem;
   logic                                     better;
   logic                                     take;

   assign cur_elem = nums_q[int'(cnt_q)*NUMBER_SIZE +: NUMBER_SIZE];
   // Strict comparison so that ties keep the earlier (lower index) winner.
   assign better   = mode_q ? (cur_elem > acc_q) : (cur_elem < acc_q);
   // The first active element loads unconditionally, whatever the accumulator holds.
   assign take     = act_q[cnt_q] && (!acc_valid_q || better);

   always_comb begin
      state_d      = state_q;
      nums_d       = nums_q;
      act_d        = act_q;
      mode_d       = mode_q;
      cnt_d        = cnt_q;
      acc_d        = acc_q;
      acc_valid_d  = acc_valid_q;
      result_d     = result_q;
      result_act_d = result_act_q;
      done_d       = 1'b0;
`ifdef ACTIVE_MIN_MAX_INDEX_EN
      acc_idx_d    = acc_idx_q;
      result_idx_d = result_idx_q;
`endif
      case (state_q)
         IDLE: begin
            if (start) begin
               nums_d      = numbers;
               act_d       = activations;
               mode_d      = mode;
               cnt_d       = '0;
               acc_d       = '0;
               acc_valid_d = 1'b0;
`ifdef ACTIVE_MIN_MAX_INDEX_EN
               acc_idx_d   = '0;
`endif
               state_d     = SCAN;
            end
         end
         SCAN: begin
            if (take) begin
               acc_d       = cur_elem;
               acc_valid_d = 1'b1;
`ifdef ACTIVE_MIN_MAX_INDEX_EN
               acc_idx_d   = cnt_q;
`endif
            end
            // Hold the counter on the last element rather than wrapping it.
            if (cnt_q == LAST_IDX) begin
               state_d = DONE;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         DONE: begin
            result_d     = acc_valid_q ? acc_q : '0;
            result_act_d = acc_valid_q;
`ifdef ACTIVE_MIN_MAX_INDEX_EN
            result_idx_d = acc_valid_q ? acc_idx_q : '0;
`endif
            done_d       = 1'b1;
            cnt_d        = '0;
            state_d      = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         nums_q       <= '0;
         act_q        <= '0;
         mode_q       <= 1'b0;
         cnt_q        <= '0;
         acc_q        <= '0;
         acc_valid_q  <= 1'b0;
         result_q     <= '0;
         result_act_q <= 1'b0;
         done_q       <= 1'b0;
`ifdef ACTIVE_MIN_MAX_INDEX_EN
         acc_idx_q    <= '0;
         result_idx_q <= '0;
`endif
      end else begin
         state_q      <= state_d;
         nums_q       <= nums_d;
         act_q        <= act_d;
         mode_q       <= mode_d;
         cnt_q        <= cnt_d;
         acc_q        <= acc_d;
         acc_valid_q  <= acc_valid_d;
         result_q     <= result_d;
         result_act_q <= result_act_d;
         done_q       <= done_d;
`ifdef ACTIVE_MIN_MAX_INDEX_EN
         acc_idx_q    <= acc_idx_d;
         result_idx_q <= result_idx_d;
`endif
      end
   end

   assign busy              = (state_q != IDLE);
   assign done              = done_q;
   assign result            = result_q;
   assign result_activation = result_act_q;
`ifdef ACTIVE_MIN_MAX_INDEX_EN
   assign result_index      = result_idx_q;
`endif

endmodule

// File: doc/active_min_max_scanner.md
ACTIVE_MIN_MAX_SCANNER -- requirements
Module: active_min_max_scanner

Interface
REQ-001 SHALL provide parameter NUMBER_SIZE, default 4, bit width of each signed number.
REQ-002 SHALL provide parameter NUMBER_OF_NUMBERS, default 8, count of candidates per scan; legal range 2..64.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port rst_n  input  1  asynchronous active-low reset.
REQ-005 SHALL provide port numbers  input  NUMBER_SIZE*NUMBER_OF_NUMBERS  packed signed candidates; element i at bits [i*NUMBER_SIZE +: NUMBER_SIZE].
REQ-006 SHALL provide port activations  input  NUMBER_OF_NUMBERS  bit i set = element i participates.
REQ-007 SHALL provide port mode  input  1  0 = minimum, 1 = maximum.
REQ-008 SHALL provide port start  input  1  request a scan; sampled only in IDLE.
REQ-009 SHALL provide port busy  output  1  high in SCAN and DONE states.
REQ-010 SHALL provide port done  output  1  one-cycle pulse; result outputs valid from this cycle.
REQ-011 SHALL provide port result  output  NUMBER_SIZE  signed extreme value of active elements.
REQ-012 SHALL provide port result_activation  output  1  high if at least one element was active.
REQ-013 SHALL provide port result_index  output  max(1,$clog2(NUMBER_OF_NUMBERS))  position of winner (only when ACTIVE_MIN_MAX_INDEX_EN defined).

Function
REQ-014 SHALL implement FSM IDLE -> SCAN -> DONE -> IDLE.
REQ-015 In IDLE, start=1 SHALL snapshot numbers, activations, mode into internal registers, clear the running accumulator (valid=0), zero the element counter, and enter SCAN.
REQ-016 In SCAN, one element per cycle SHALL be examined in ascending index order, counter 0..NUMBER_OF_NUMBERS-1; after last element state SHALL go to DONE.
REQ-017 Inactive elements SHALL be skipped without altering the accumulator.
REQ-018 First active element SHALL load the accumulator unconditionally and set valid.
REQ-019 Later active element SHALL replace accumulator iff strictly less (mode 0) or strictly greater (mode 1) under signed comparison; ties keep the lower index.
REQ-020 In DONE, result, result_activation, result_index SHALL be registered from accumulator, done SHALL pulse for exactly one cycle, then state returns to IDLE.
REQ-021 Latency: start sampled on edge 0 SHALL give done high in the cycle after edge NUMBER_OF_NUMBERS+1.
REQ-022 If no element active, result SHALL be 0, result_index 0, result_activation 0.
REQ-023 result outputs SHALL hold their last DONE value until the next DONE; changes on numbers/activations/mode during a scan SHALL have no effect.
REQ-024 start while busy SHALL be ignored (not queued); start held high continuously SHALL begin a new scan on the first IDLE cycle after DONE.
REQ-025 Counter SHALL not wrap beyond NUMBER_OF_NUMBERS-1.

Reset
REQ-026 rst_n low SHALL immediately force IDLE, busy=0, done=0, result=0, result_activation=0, result_index=0, accumulator and counter cleared, regardless of state.
REQ-027 Reset mid-scan SHALL abort without a done pulse; first scan after release SHALL behave as from power-up.

Configuration
REQ-028 Macro ACTIVE_MIN_MAX_INDEX_EN defined: winner index tracked and result_index port present per REQ-013/019/020/022.
REQ-029 Macro undefined: result_index port and index register absent; all other behaviour unchanged.

Verification
REQ-030 N=8, NS=4, mode 0, numbers {3,-2,5,-2,7,0,1,4}, all active, start -> done at cycle 10, result=-2, index 1, activation 1.
REQ-031 Same numbers, mode 1, activations 8'b0000_1111 -> result=5, index 2.
REQ-032 activations 0, start -> result=0, result_activation=0, index 0, done still pulses.
REQ-033 Extremes: mode 0 with -8 at index 7 and 7 elsewhere -> result=-8 (signed, not unsigned).
REQ-034 Start pulses and input changes during SCAN -> ignored, single done, result from snapshot.
REQ-035 rst_n low at scan cycle 4 -> outputs zero, no done; next scan correct.
